// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that owns one shared WIDTH-bit register and writes it for one requester at a time.
// Optional lock chaining of back-to-back writes is enabled with `define ARB_LOCK_EN.
module shared_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
`ifdef ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 4
`endif
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] Data,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]       Lock,
`endif
  output logic [N_REQ-1:0]       Grant,
  output logic [N_REQ-1:0]       Ack,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       Qbar,
  output logic                   Busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   g_q, g_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [PTR_W-1:0]   ptr_next_s;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
`endif

  // First requester with Req set, searching upward from ptr with wrap-around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W:0]   sum;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end else begin
        sum = sum;
      end
      if (!found && req[sum[PTR_W-1:0]]) begin
        pick  = sum[PTR_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign ptr_next_s = (g_q == PTR_W'(N_REQ - 1)) ? '0 : g_q + PTR_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    q_d     = q_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ack_d = '0;
        if (|Req) begin
          g_d     = rr_pick(Req, ptr_q);
          grant_d = onehot(g_d);
          state_d = ST_GRANT;
        end else begin
          grant_d = '0;
        end
      end
      ST_GRANT: begin
        grant_d = '0;
        if (Req[g_q]) begin
          q_d     = Data[g_q*WIDTH +: WIDTH];
          ack_d   = onehot(g_q);
          state_d = ST_WRITE;
        end else begin
          ack_d   = '0;
          state_d = ST_IDLE;
`ifdef ARB_LOCK_EN
          lock_cnt_d = '0;
`endif
        end
      end
      ST_WRITE: begin
        ack_d = '0;
`ifdef ARB_LOCK_EN
        // Chain straight back to GRANT while the owner keeps its lock, up to LOCK_MAX writes.
        if (Lock[g_q] && Req[g_q] && (lock_cnt_q < LOCK_LAST)) begin
          grant_d    = onehot(g_q);
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
          state_d    = ST_GRANT;
        end else begin
          grant_d    = '0;
          lock_cnt_d = '0;
          ptr_d      = ptr_next_s;
          state_d    = ST_IDLE;
        end
`else
        grant_d = '0;
        ptr_d   = ptr_next_s;
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ack_d   = '0;
      end
    endcase
  end

  // State, pointer and shared register; synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      q_q     <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign Grant = grant_q;
  assign Ack   = ack_q;
  assign Q     = q_q;
  assign Qbar  = ~q_q;
  assign Busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (default build) against a transaction-level model.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           resetn;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [W-1:0]   qbar;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Model state: round-robin pointer and shared register contents.
  int           ptr_m = 0;
  logic [W-1:0] q_m   = '0;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .Clock (clk),
    .Resetn(resetn),
    .Req   (req),
    .Data  (data),
    .Grant (grant),
    .Ack   (ack),
    .Q     (q),
    .Qbar  (qbar),
    .Busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round starting in IDLE. hold keeps Req/Data constant throughout.
  task automatic do_txn(input logic [N-1:0] r, input logic [N*W-1:0] d,
                        input bit abort, input bit hold, output int winner);
    int           w;
    logic [N-1:0] nr;
    req  = r;
    data = d;
    step();
    w = model_pick(r, ptr_m);
    winner = w;
    if (w < 0) begin
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_grant", {28'd0, grant}, 32'd0);
      return;
    end
    check_val("grant", {28'd0, grant}, {28'd0, oh(w)});
    check_val("grant_ack", {28'd0, ack}, 32'd0);
    check_val("grant_busy", {31'd0, busy}, 32'd1);
    if (hold) begin
      nr = r;
    end else begin
      nr   = N'($urandom);
      data = $urandom;
    end
    nr[w] = !abort;
    req   = nr;
    step();
    if (abort) begin
      check_val("abort_ack", {28'd0, ack}, 32'd0);
      check_val("abort_grant", {28'd0, grant}, 32'd0);
      check_val("abort_q", {24'd0, q}, {24'd0, q_m});
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      return;
    end
    q_m   = data[w*W +: W];
    ptr_m = (w + 1) % N;
    check_val("write_ack", {28'd0, ack}, {28'd0, oh(w)});
    check_val("write_grant", {28'd0, grant}, 32'd0);
    check_val("write_q", {24'd0, q}, {24'd0, q_m});
    check_val("write_qbar", {24'd0, qbar}, {24'd0, ~q_m});
    check_val("write_busy", {31'd0, busy}, 32'd1);
    if (!hold) begin
      req  = N'($urandom);
      data = $urandom;
    end
    step();
    check_val("post_ack", {28'd0, ack}, 32'd0);
    check_val("post_busy", {31'd0, busy}, 32'd0);
    check_val("post_q", {24'd0, q}, {24'd0, q_m});
  endtask

  initial begin
    int           w;
    logic [N-1:0] r;
    resetn = 1'b0;
    req    = 4'b1111;
    data   = 32'h0;

    // Reset with all requests pending.
    step();
    step();
    check_val("rst_grant", {28'd0, grant}, 32'd0);
    check_val("rst_ack", {28'd0, ack}, 32'd0);
    check_val("rst_q", {24'd0, q}, 32'h00);
    check_val("rst_qbar", {24'd0, qbar}, 32'hFF);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;

    // Single request from requester 2.
    do_txn(4'b0100, 32'h00A5_0000, 1'b0, 1'b1, w);
    check_val("single_winner", w, 2);
    check_val("single_qbar", {24'd0, qbar}, 32'h5A);

    // Reset mid-grant; ptr must return to 0.
    req = 4'b0100;
    step();
    check_val("mid_grant", {28'd0, grant}, 32'b0100);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    req    = 4'b0000;
    ptr_m  = 0;
    q_m    = '0;
    check_val("midrst_q", {24'd0, q}, 32'h00);
    check_val("midrst_grant", {28'd0, grant}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("midrst_noack", {28'd0, ack}, 32'd0);
      step();
    end

    // Fairness: all requesting, data 10..13.
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, 32'h1312_1110, 1'b0, 1'b1, w);
      check_val("fair_order", w, k % N);
    end

    // Abort keeps ptr: write by 0 sets ptr to 1, abort 1, then 0011 must pick 1.
    do_txn(4'b0001, 32'h0000_0077, 1'b0, 1'b1, w);
    do_txn(4'b0010, 32'h0000_EE00, 1'b1, 1'b1, w);
    check_val("abort_q_kept", {24'd0, q}, 32'h77);
    do_txn(4'b0011, 32'h0000_3344, 1'b0, 1'b1, w);
    check_val("abort_ptr", w, 1);

    // Randomized rounds with aborts and noise on non-granted lines.
    for (int n = 0; n < 300; n++) begin
      r = N'($urandom);
      do_txn(r, $urandom, ($urandom_range(0, 4) == 0), 1'b0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin controller that shares a single WIDTH-bit register bank among N_REQ requesters. The bank uses the same D-flip-flop storage with complementary outputs as the team's D_ff cells. The block grants one requester at a time, loads that requester's data into the shared register, and acknowledges the write. It sits between requester blocks and the shared storage element, and is the only writer of that element.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- LOCK_MAX, 4, max consecutive locked writes (used only with ARB_LOCK_EN)

- Clock  input  1  single clock; all state updates on rising edge
- Resetn  input  1  synchronous, active-low reset, sampled on rising edge of Clock
- Req  input  N_REQ  per-requester write request, level, held until Ack
- Data  input  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- Lock  input  N_REQ  lock request (present only with ARB_LOCK_EN)
- Grant  output  N_REQ  one-hot registered grant
- Ack  output  N_REQ  one-hot, one-cycle write acknowledge
- Q  output  WIDTH  shared register contents
- Qbar  output  WIDTH  bitwise complement of Q, always
- Busy  output  1  high when state is not IDLE

## Operation
- States: IDLE, GRANT, WRITE. Round-robin pointer ptr has log2(N_REQ) bits.
- IDLE: if any Req is high, select g = the first requester with Req high, searching from ptr upward with wrap-around. Set Grant = onehot(g) and go to GRANT. If no Req is high, stay in IDLE.
- GRANT: Grant[g] is high.
  - If Req[g] is still high: Q <= Data[g], Grant <= 0, Ack <= onehot(g), go to WRITE.
  - If Req[g] dropped: abort. Grant <= 0, go to IDLE. No write, no Ack, ptr unchanged.
- WRITE: Ack is high for exactly this cycle. ptr <= (g+1) mod N_REQ. Go to IDLE. Ack clears on the next edge.
- Req changes on non-granted lines while in GRANT or WRITE are ignored until the next IDLE evaluation.
- Data is sampled only on the GRANT->WRITE edge.
- Q is held in all other states.
- Qbar = ~Q combinationally from the register, so it is never out of phase with Q.
- Grant and Ack are never high together. Each has at most one bit set.
- Reset (Resetn low at an edge), in any state including mid-grant:
  - state = IDLE, ptr = 0
  - Grant = 0, Ack = 0, Busy = 0
  - Q = 0, Qbar = all ones
  - No partial write occurs.

## Timing
- Req[i] high at edge t while in IDLE, with i winning: Grant[i] high from t+1. Q = Data[i] and Ack[i] high from t+2. Busy low again from t+3.
- Minimum write cadence for one requester: 3 cycles (IDLE, GRANT, WRITE). Without lock, a continuously requesting single requester gets one write every 3 cycles.
- All outputs are registered except Qbar, which is an inverter on Q. Busy is decoded from the state register.

## Configuration
- ARB_LOCK_EN defined:
  - Adds the Lock port and a lock counter.
  - In WRITE, if Lock[g] and Req[g] are high and fewer than LOCK_MAX consecutive writes have completed, the block goes directly to GRANT for the same g. ptr does not advance.
  - Otherwise the block behaves as without the macro. The counter clears on leaving the lock or on reset.
  - Locked back-to-back writes occur every 2 cycles.
- ARB_LOCK_EN undefined: no Lock port, no counter, pure round-robin as specified above.

## Test plan
- Reset: drive Resetn low for 2 edges with Req = 4'b1111 -> Grant = 0, Ack = 0, Q = 8'h00, Qbar = 8'hFF, Busy = 0.
- Single request: Req = 4'b0100, Data[2] = 8'hA5 -> Grant = 4'b0100 at t+1; Q = 8'hA5, Qbar = 8'h5A, Ack = 4'b0100 at t+2; Busy = 0 at t+3.
- Fairness: Req = 4'b1111 held, data 8'h10/11/12/13 -> Ack order 0, 1, 2, 3, 0, with Q following 10, 11, 12, 13, 10; one Ack every 3 cycles.
- Abort: Req = 4'b0010, drop Req[1] during GRANT -> no Ack, Q unchanged, state back to IDLE, ptr still selects requester 1 first on the next contention with Req = 4'b0011.
- Reset mid-grant: assert Resetn low during GRANT -> Q = 8'h00, no Ack ever pulses, ptr = 0.
- (ARB_LOCK_EN) LOCK_MAX = 4, Req = 4'b0011, Lock[0] held -> four writes by requester 0 at 2-cycle spacing, then the grant goes to requester 1.
